// File: rtl/addsub_rr_sched_pkg.sv
// Shared FIR datapath definitions: operand width, scheduler sizing,
// saturation limits and the add/sub scheduler state encoding.
package FirPkg;

    localparam int DATA_WIDTH    = 16;
    localparam int SCHED_NUM_REQ = 4;

    // Largest positive and most negative two's-complement values
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } addsub_sched_state_e;

endpackage

// File: rtl/addsub_nbit.sv
// N-bit two's-complement adder/subtractor built from 4-bit ripple slices.
// add_sub=1 computes a-b as a+~b+1; carry_o=1 then means "no borrow".
module addsub_nbit
    import FirPkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                add_sub,
    output logic signed [W-1:0] S,
    output logic                V,
    output logic                carry_o
);

    localparam int NIB = W / 4;

    logic [W-1:0] b_eff;
    logic [NIB:0] c;

    assign b_eff = add_sub ? ~b : b;
    assign c[0]  = add_sub;

    for (genvar i = 0; i < NIB; i++) begin : g_nib
        assign {c[i+1], S[4*i +: 4]} = {1'b0, a[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + {4'b0, c[i]};
    end

    // Signed overflow: both effective operands agree in sign, result disagrees
    assign V       = (a[W-1] == b_eff[W-1]) && (S[W-1] != a[W-1]);
    assign carry_o = c[NIB];

endmodule

// File: rtl/addsub_rr_sched_arbiter.sv
// Round-robin arbiter: searches last+1, last+2, ... modulo N and grants the
// first requester found. Nothing is granted while enable is low.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Rotating priority search starting just after the last winner
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ID_W'((int'(last) + i) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one add/sub datapath between NUM_REQ
// requesters. One transaction in flight: grant -> EXEC -> HOLD (response
// held until accepted). A new grant may overlap the response handshake.
module addsub_rr_sched
    import FirPkg::*;
#(
    parameter int NUM_REQ = SCHED_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic signed [DATA_WIDTH-1:0] req_a [NUM_REQ],
    input  logic signed [DATA_WIDTH-1:0] req_b [NUM_REQ],
    input  logic [NUM_REQ-1:0]           req_sub,
    input  logic [NUM_REQ-1:0]           req_sat,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [DATA_WIDTH-1:0] rsp_data,
    output logic                         rsp_ovf,
    output logic                         rsp_carry,
    output logic [ID_W-1:0]              rsp_id
);

    addsub_sched_state_e state_q, state_next;

    logic signed [DATA_WIDTH-1:0] a_q, b_q;
    logic                         sub_q, sat_q;
    logic [ID_W-1:0]              id_q, last_q;

    logic                         arb_en;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_W-1:0]              grant_idx;

    logic signed [DATA_WIDTH-1:0] sum;
    logic                         sum_v, sum_c;

    // Clamp toward the sign of A when signed overflow occurs; A's sign is
    // the overflow direction for both add and subtract.
    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [DATA_WIDTH-1:0] s,
        input logic                         v,
        input logic                         sat,
        input logic                         a_msb
    );
        if (sat && v) return a_msb ? SAT_MIN : SAT_MAX;
        return s;
    endfunction

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .last      (last_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    addsub_nbit #(
        .W (DATA_WIDTH)
    ) u_addsub (
        .a       (a_q),
        .b       (b_q),
        .add_sub (sub_q),
        .S       (sum),
        .V       (sum_v),
        .carry_o (sum_c)
    );

    assign req_ready = grant;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (|grant) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (rsp_ready) state_next = (|grant) ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbiter enable: idle, or the cycle the pending response is accepted
    always_comb begin
        arb_en = 1'b0;
        case (state_q)
            IDLE:    arb_en = rst_n;
            HOLD:    arb_en = rst_n && rsp_ready;
            default: arb_en = 1'b0;
        endcase
    end

    // Operand capture on grant; last_q seeds the next round-robin search
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            sat_q  <= 1'b0;
            id_q   <= '0;
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (|grant) begin
            a_q    <= req_a[grant_idx];
            b_q    <= req_b[grant_idx];
            sub_q  <= req_sub[grant_idx];
            sat_q  <= req_sat[grant_idx];
            id_q   <= grant_idx;
            last_q <= grant_idx;
        end
    end

    // Response registers: load in EXEC, hold until the handshake in HOLD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= saturate(sum, sum_v, sat_q, a_q[DATA_WIDTH-1]);
            rsp_ovf   <= sum_v;
            rsp_carry <= sum_c;
            rsp_id    <= id_q;
        end else if (state_q == HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Scoreboard bench for addsub_rr_sched: requester queues drive operands,
// a cycle model predicts grants, and expected responses are queued at grant
// and compared while the response is held.
module tb_addsub_rr_sched;
    import FirPkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         sat;
    } op_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          ovf;
        logic          carry;
        logic [IW-1:0] id;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic signed [W-1:0] req_a [N];
    logic signed [W-1:0] req_b [N];
    logic [N-1:0]        req_sub;
    logic [N-1:0]        req_sat;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_data;
    logic                rsp_ovf;
    logic                rsp_carry;
    logic [IW-1:0]       rsp_id;

    always #5 clk = ~clk;

    addsub_rr_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_sat   (req_sat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    op_t    opq [N][$];
    rsp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    logic         m_exec = 1'b0;
    logic         m_hold = 1'b0;
    int           m_last = N - 1;
    logic [N-1:0] granted = '0;
    logic         rst_done = 1'b0;
    int           cyc = 0;
    logic         logging = 1'b0;
    int           id_log[$];
    int           cyc_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] r;
        r = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic rsp_t model(input op_t op, input int id);
        int           sa, sbv, r;
        logic [W:0]   t;
        rsp_t         e;
        sa  = int'($signed(op.a));
        sbv = int'($signed(op.b));
        r   = op.sub ? sa - sbv : sa + sbv;
        e.ovf  = (r > 32767) || (r < -32768);
        e.data = r[W-1:0];
        if (e.ovf && op.sat) e.data = (r > 0) ? 16'h7FFF : 16'h8000;
        t = {1'b0, op.a} + {1'b0, op.b};
        e.carry = op.sub ? (op.a >= op.b) : t[W];
        e.id    = IW'(id);
        return e;
    endfunction

    always @(posedge clk) rst_done <= !rst_n;

    // Cycle model, grant prediction and scoreboard comparison
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           win;
        rsp_t         e;
        exp_rdy = '0;
        win     = 0;
        if (rst_n && !m_exec && (!m_hold || rsp_ready)) exp_rdy = rr_pick(req_valid, m_last);
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_hold));
        if (!rst_n && rst_done) begin
            check_eq("rst_rsp_data", 32'(rsp_data), 32'h0);
            check_eq("rst_rsp_flags", {29'b0, rsp_ovf, rsp_carry, rsp_valid}, 32'h0);
            check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
        end
        if (m_hold) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'h0, 32'h1);
            end else begin
                e = sb[0];
                check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
                check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
                check_eq("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                check_eq("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    if (logging) begin
                        id_log.push_back(int'(e.id));
                        cyc_log.push_back(cyc);
                    end
                end
            end
        end
        granted = req_ready & req_valid;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) win = i;
        if (exp_rdy != '0)
            sb.push_back(model(op_t'{a: req_a[win], b: req_b[win], sub: req_sub[win], sat: req_sat[win]}, win));
        if (!rst_n) begin
            m_exec = 1'b0;
            m_hold = 1'b0;
            m_last = N - 1;
            sb.delete();
        end else begin
            m_hold = m_exec || (m_hold && !rsp_ready);
            m_exec = (exp_rdy != '0);
            if (exp_rdy != '0) m_last = win;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (granted[i] && opq[i].size() != 0) void'(opq[i].pop_front());
            req_valid[i] = (opq[i].size() != 0);
            if (req_valid[i]) begin
                req_a[i]   = opq[i][0].a;
                req_b[i]   = opq[i][0].b;
                req_sub[i] = opq[i][0].sub;
                req_sat[i] = opq[i][0].sat;
            end else begin
                req_a[i]   = W'($urandom);
                req_b[i]   = W'($urandom);
                req_sub[i] = 1'($urandom);
                req_sat[i] = 1'($urandom);
            end
        end
    endtask

    function automatic logic all_idle();
        logic q_empty;
        q_empty = 1'b1;
        for (int i = 0; i < N; i++) if (opq[i].size() != 0) q_empty = 1'b0;
        return q_empty && sb.size() == 0 && !m_hold && !m_exec && req_valid == '0;
    endfunction

    task automatic drain();
        rsp_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (all_idle()) break;
            step();
        end
        check_eq("drain_done", 32'(all_idle()), 32'h1);
    endtask

    task automatic push_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic sat);
        opq[r].push_back(op_t'{a: a, b: b, sub: sub, sat: sat});
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_sub   = '0;
        req_sat   = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end

        // Reset with all requesters pending, then directed add/sub/saturation
        push_op(0, 16'h0005, 16'h0003, 1'b0, 1'b0);
        push_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1);
        push_op(1, 16'h0005, 16'h0003, 1'b1, 1'b0);
        push_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        push_op(3, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        step();
        check_eq("rst_valid_all", 32'(req_valid), 32'hF);
        repeat (3) step();
        rst_n = 1'b1;
        drain();

        // Fairness from a fresh reset: all four held valid
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_op(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            push_op(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        id_log.delete();
        cyc_log.delete();
        logging = 1'b1;
        drain();
        logging = 1'b0;
        check_eq("rr_count", 32'(id_log.size()), 32'd8);
        for (int k = 0; k < id_log.size(); k++) begin
            check_eq("rr_order", 32'(id_log[k]), 32'(k % N));
            if (k > 0) check_eq("rr_spacing", 32'(cyc_log[k] - cyc_log[k-1]), 32'd2);
        end

        // Backpressure in HOLD with requesters 1 and 2 waiting
        rsp_ready = 1'b0;
        push_op(0, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        step();
        step();
        push_op(1, 16'h4000, 16'h4000, 1'b0, 1'b1);
        push_op(2, 16'hC000, 16'h4001, 1'b1, 1'b1);
        step();
        repeat (5) step();
        check_eq("bp_valid_pins", 32'(req_valid), 32'h6);
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        id_log.delete();
        logging = 1'b1;
        drain();
        logging = 1'b0;
        check_eq("bp_count", 32'(id_log.size()), 32'd3);
        if (id_log.size() == 3) check_eq("bp_next_id", 32'(id_log[1]), 32'd1);

        // Reset during EXEC: the in-flight transaction disappears
        push_op(2, 16'h0100, 16'h0001, 1'b0, 1'b0);
        step();
        step();
        push_op(0, 16'h0011, 16'h0022, 1'b0, 1'b0);
        push_op(3, 16'h0033, 16'h0044, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        id_log.delete();
        logging = 1'b1;
        drain();
        logging = 1'b0;
        check_eq("rst_mid_count", 32'(id_log.size()), 32'd2);
        if (id_log.size() != 0) check_eq("rst_first_id", 32'(id_log[0]), 32'd0);

        // Random traffic with random backpressure
        for (int k = 0; k < 16; k++)
            push_op($urandom_range(0, N - 1), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 0; k < 80; k++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_rr_sched.md
# addsub_rr_sched

Round-robin scheduler that shares one `addsub_nbit` datapath between `NUM_REQ` requesters in the FIR pipeline, such as the tap accumulators and coefficient-update logic. It arbitrates per-requester valid/ready operand requests and runs one add or subtract at a time. The result, carry and overflow are returned on a registered valid/ready response port, tagged with the requester ID. Optional signed saturation is selected per transaction.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `DATA_WIDTH`, from `FirPkg`: operand width, a multiple of 4 (inherited from the datapath).
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  [NUM_REQ]: request pending, one bit per requester.
- `req_ready`  out  [NUM_REQ]: one-hot grant/accept; at most one bit high.
- `req_a`, `req_b`  in  [NUM_REQ][DATA_WIDTH]: signed two's-complement operands.
- `req_sub`  in  [NUM_REQ]: 0 computes A+B, 1 computes A−B.
- `req_sat`  in  [NUM_REQ]: 1 clamps the result on signed overflow.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_data`  out  DATA_WIDTH: the result, saturated if requested.
- `rsp_ovf`  out  1: raw signed overflow V from the datapath, independent of saturation.
- `rsp_carry`  out  1: raw carry-out. For subtraction, 1 means no borrow.
- `rsp_id`  out  ID_W: index of the requester that issued the result.

## Operation
- FSM states: `IDLE`, `EXEC`, `HOLD`.
- **IDLE**
  - If any `req_valid` is high, a grant is issued that cycle: `req_ready[g]`=1 for the round-robin winner g, combinationally.
  - On the edge: latch `req_a[g]`, `req_b[g]`, `req_sub[g]` and `req_sat[g]` into operand registers; set `id_q`=g and `last_q`=g; go to `EXEC`.
- **EXEC**
  - `addsub_nbit` evaluates the latched operands, with `add_sub`=sub_q.
  - On the edge: register `S`, `V` and `carry_o` into the response registers, applying saturation; go to `HOLD`.
- **HOLD**
  - `rsp_valid`=1; the response outputs stay stable until the handshake completes.
  - On `rsp_ready`=1: if any `req_valid` is high, the next grant is issued in that same cycle and the FSM goes to `EXEC`; otherwise it goes to `IDLE`.
  - On `rsp_ready`=0: stay in `HOLD`; all `req_ready` are 0.
- **Round-robin**
  - Search order is `last_q+1`, `last_q+2`, …, wrapping modulo NUM_REQ.
  - A requester that was just served has the lowest priority next time.
  - Requesters without `req_valid` are skipped with no penalty.
- **Saturation**
  - Applies when sat_q=1 and V=1.
  - If A[MSB]=0, the result is 0x7F…F; otherwise it is 0x80…0. This rule is correct for both add and subtract.
  - `rsp_ovf` still reports 1.
- **Requester obligations**
  - A requester holds `req_valid` and its operands stable until it sees `req_ready`.
  - The scheduler never drops a valid request.
  - Deasserting `req_valid` without a grant is permitted; that requester is simply not selected.
- **Reset** (`rst_n`=0 at an edge, including mid-transaction)
  - state=`IDLE`, `last_q`=NUM_REQ−1 so requester 0 wins first.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_ovf`=0, `rsp_carry`=0, `rsp_id`=0; operand registers cleared.
  - `req_ready` is forced to 0 while `rst_n` is low.
  - An in-flight transaction is discarded with no response.

## Timing
- **Latency:** grant at edge k gives `rsp_valid` high after edge k+2.
- **Throughput:** one transaction per 2 cycles with `rsp_ready` held high (handshake plus new grant in the `HOLD` cycle).
- `req_ready` is combinational from `req_valid`, state, `rsp_ready` and `last_q`. All `rsp_*` outputs are registered.
- Only one transaction is in flight; no response buffering.
- **Simultaneous events:** in `HOLD` with `rsp_ready`=1 and new requests present, the response completes and the next grant happens in the same cycle. The next `rsp_valid` goes high 2 edges later, so `rsp_valid` shows one low cycle between results.

## Structure
- Add to `FirPkg`:
  - the `addsub_sched_state_e` enum (`IDLE`, `EXEC`, `HOLD`);
  - `SCHED_NUM_REQ` (default 4);
  - `SAT_MAX`/`SAT_MIN` constants derived from `DATA_WIDTH`.
- Instantiate exactly one existing `addsub_nbit` as `u_addsub`.
- Implement the arbiter as the sub-module `rr_arbiter`, with inputs `req`, `last`, `enable` and outputs `grant` (one-hot) and `grant_idx`.

## Test plan
All values assume `DATA_WIDTH`=16.
- **Reset/idle:** hold `rst_n`=0 for 3 cycles with `req_valid`=4'b1111 → all `req_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- **Single add:** req0 A=0x0005, B=0x0003, sub=0 → grant on the first cycle after reset. 2 edges later: `rsp_data`=0x0008, `rsp_id`=0, `rsp_ovf`=0.
- **Subtract, overflow, saturation:**
  - req1 A=0x0005, B=0x0003, sub=1 → `rsp_data`=0x0002, `rsp_carry`=1.
  - A=0x7FFF, B=0x0001, sub=0, sat=0 → `rsp_data`=0x8000, `rsp_ovf`=1.
  - Same with sat=1 → `rsp_data`=0x7FFF, `rsp_ovf`=1.
  - A=0x8000, B=0x0001, sub=1, sat=1 → `rsp_data`=0x8000, `rsp_ovf`=1.
- **Round-robin fairness:** all 4 requesters held valid, `rsp_ready`=1 → `rsp_id` sequence is 0,1,2,3,0,1; results arrive every 2 cycles.
- **Backpressure:** `rsp_ready`=0 for 5 cycles while `HOLD` with `req_valid`=4'b0110 → `rsp_*` outputs stable and `req_ready`=0 throughout. On release, grant is issued in the same cycle to the next requester after `last_q`.
- **Reset mid-operation:** assert `rst_n`=0 during `EXEC` → no response appears, and after release requester 0 has first priority.
